game_phase_sequencer: RTL and testbench
=======================================

Name: game_phase_sequencer

Overview:
- Top-level screen/phase controller for the game. It sequences logo → mode select → tutorial or match → score board → play-again prompt.
- Owns the 1-second prescaler and the match countdown. Drives one-hot screen-enable flags and the snitch power-up window.
- Sits between the input/mode-select logic and the VGA screen mux/scoring blocks; replaces free-running cycle counters with a single reset-clean FSM.

Parameters:
- CLK_HZ, 50000000, clock cycles per second tick (≥2)
- LOGO_SECS, 5, seconds the logo screen is shown
- GAME_SECS, 50, match length in seconds (1..255)
- SNITCH_HI, 40, snitch window upper bound on time_left (inclusive)
- SNITCH_LO, 36, snitch window lower bound on time_left (inclusive, ≤SNITCH_HI)
- SCORE_SECS, 4, seconds the score board is held before the play-again prompt

Ports:
- clock  in  1  system clock
- resetn  in  1  asynchronous active-low reset
- sel_single  in  1  single-player mode chosen (level, sampled in SELECT)
- sel_two_player  in  1  two-player mode chosen
- sel_tutorial  in  1  tutorial chosen
- end_game_early  in  1  abort match/tutorial to score board
- end_tutorial  in  1  tutorial complete
- restart  in  1  player requests a new game (sampled in PLAY_AGAIN)
- phase  out  3  current state encoding
- logo  out  1  logo screen enable
- select_mode_screen  out  1  mode-select screen enable
- tutorial_active  out  1  tutorial screen enable
- game_active  out  1  match running
- two_player_mode  out  1  latched mode for current match
- end_of_game  out  1  score-board screen enable
- play_again  out  1  play-again prompt enable
- snitch_powerup  out  1  snitch window active
- time_left  out  8  match seconds remaining
- sec_tick  out  1  one-cycle pulse at each second boundary

Behaviour:
- Decided interface: one clock; reset is asynchronous and active-low. Ports are named clock and resetn.
- Reset values: phase=LOGO(0), logo=1, all other flags 0, time_left=0, prescaler=0, two_player_mode=0.
- States and encodings: LOGO=0, SELECT=1, TUTORIAL=2, GAME=3, SCORE=4, AGAIN=5. Codes 6 and 7 return to LOGO on the next clock.
- Prescaler: counts 0..CLK_HZ-1. sec_tick=1 in the cycle the count equals CLK_HZ-1, then the count wraps to 0. It clears to 0 on every state transition, so every timed phase starts on a whole-second boundary.
- Phase seconds counter (8 bit) clears on every transition and increments on each sec_tick.
- Flags are registered and one-hot with phase. Each flag is 1 exactly while its state is current: logo↔LOGO, select_mode_screen↔SELECT, tutorial_active↔TUTORIAL, game_active↔GAME, end_of_game↔SCORE, play_again↔AGAIN.
- LOGO → SELECT on the sec_tick that brings phase seconds to LOGO_SECS. Duration is exactly LOGO_SECS×CLK_HZ cycles.
- SELECT: priority is sel_two_player > sel_single > sel_tutorial.
  - sel_two_player → GAME with two_player_mode=1.
  - sel_single → GAME with two_player_mode=0.
  - sel_tutorial → TUTORIAL.
  - On GAME entry, time_left loads GAME_SECS in the same clock.
- GAME:
  - time_left decrements on each sec_tick.
  - On the sec_tick where time_left==1: time_left becomes 0 and the state goes to SCORE.
  - end_game_early → SCORE on the next clock, taking precedence over a simultaneous tick; time_left holds its value.
- TUTORIAL: end_tutorial or end_game_early → SCORE.
- snitch_powerup = game_active AND SNITCH_LO ≤ time_left ≤ SNITCH_HI, registered from the next-state values so it is aligned with time_left.
- SCORE → AGAIN after SCORE_SECS ticks. Inputs are ignored in SCORE.
- AGAIN:
  - restart → SELECT; time_left clears and two_player_mode clears.
  - sel_* inputs are ignored in AGAIN.
  - The state holds indefinitely without restart.
- Mode and restart inputs are level inputs that are already synchronised and debounced upstream; no edge detection is done here.
- Reset mid-operation: asynchronous return to reset values within the same cycle as resetn falling. After resetn rises, the prescaler restarts from 0.
- Width rule: prescaler width is clog2(CLK_HZ); time_left never underflows below 0.

Test Plan:
- Bench parameters for all scenarios: CLK_HZ=4, LOGO_SECS=2, GAME_SECS=5, SNITCH_HI=4, SNITCH_LO=3, SCORE_SECS=1.
- Reset release, no inputs → logo=1 for exactly 8 cycles, then select_mode_screen=1 and holds; sec_tick pulses every 4 cycles.
- In SELECT, assert sel_single and sel_two_player together → GAME, two_player_mode=1, time_left=5. time_left then steps 4,3,2,1,0 at 4-cycle spacing. snitch_powerup=1 only while time_left∈{4,3} (8 cycles). SCORE is entered in the same clock time_left hits 0.
- SCORE held 4 cycles → AGAIN. play_again holds with no restart for 100 cycles. restart → SELECT with time_left=0 and two_player_mode=0.
- In GAME at time_left=3, pulse end_game_early coincident with sec_tick → next phase=SCORE, time_left stays 3, snitch_powerup=0.
- sel_tutorial only → TUTORIAL, tutorial_active=1, time_left=0. end_tutorial → SCORE, end_of_game=1 for 4 cycles.
- Assert resetn=0 mid-GAME for 1 cycle → phase=0, logo=1, time_left=0 immediately. A full 8-cycle logo phase follows.

Source files
------------

// File: rtl/game_phase_sequencer.sv
// Top-level phase controller: logo -> mode select -> tutorial or match ->
// score board -> play-again prompt. Owns the one-second prescaler, the
// per-phase seconds counter and the match countdown. All screen-enable
// flags are registered from the next-state value, so they stay one-hot
// with phase. The FSM state is visible on the phase output.
module game_phase_sequencer #(
  parameter int CLK_HZ     = 50000000,
  parameter int LOGO_SECS  = 5,
  parameter int GAME_SECS  = 50,
  parameter int SNITCH_HI  = 40,
  parameter int SNITCH_LO  = 36,
  parameter int SCORE_SECS = 4
) (
  input  logic       clock,
  input  logic       resetn,
  input  logic       sel_single,
  input  logic       sel_two_player,
  input  logic       sel_tutorial,
  input  logic       end_game_early,
  input  logic       end_tutorial,
  input  logic       restart,
  output logic [2:0] phase,
  output logic       logo,
  output logic       select_mode_screen,
  output logic       tutorial_active,
  output logic       game_active,
  output logic       two_player_mode,
  output logic       end_of_game,
  output logic       play_again,
  output logic       snitch_powerup,
  output logic [7:0] time_left,
  output logic       sec_tick
);

  // Prescaler width follows the tick rate; a floor of 1 bit keeps the
  // declaration legal for the smallest permitted rate.
  localparam int PW = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;

  localparam logic [PW-1:0] PRESC_LAST   = PW'(CLK_HZ - 1);
  localparam logic [7:0]    LOGO_LEN     = 8'(LOGO_SECS);
  localparam logic [7:0]    GAME_LEN     = 8'(GAME_SECS);
  localparam logic [7:0]    SCORE_LEN    = 8'(SCORE_SECS);
  localparam logic [7:0]    SNITCH_TOP   = 8'(SNITCH_HI);
  localparam logic [7:0]    SNITCH_FLOOR = 8'(SNITCH_LO);

  typedef enum logic [2:0] {
    ST_LOGO     = 3'd0,
    ST_SELECT   = 3'd1,
    ST_TUTORIAL = 3'd2,
    ST_GAME     = 3'd3,
    ST_SCORE    = 3'd4,
    ST_AGAIN    = 3'd5,
    ST_BAD6     = 3'd6,
    ST_BAD7     = 3'd7
  } state_e;

  state_e          state_q, state_d;
  logic [PW-1:0]   presc_q, presc_d;
  logic [7:0]      secs_q, secs_d;
  logic [7:0]      time_left_q, time_left_d;
  logic            two_player_q, two_player_d;
  logic            logo_q, logo_d;
  logic            select_q, select_d;
  logic            tutorial_q, tutorial_d;
  logic            game_q, game_d;
  logic            score_q, score_d;
  logic            again_q, again_d;
  logic            snitch_q, snitch_d;

  logic            tick;
  logic            transition;
  logic [7:0]      secs_inc;

  // Second boundary is the last count of the prescaler.
  always_comb begin
    tick     = (presc_q == PRESC_LAST);
    secs_inc = secs_q + 8'd1;
  end

  // Next-state, match countdown and latched mode.
  always_comb begin
    state_d      = state_q;
    time_left_d  = time_left_q;
    two_player_d = two_player_q;
    case (state_q)
      ST_LOGO: begin
        if (tick && (secs_inc == LOGO_LEN)) begin
          state_d = ST_SELECT;
        end
      end
      ST_SELECT: begin
        if (sel_two_player) begin
          state_d      = ST_GAME;
          two_player_d = 1'b1;
          time_left_d  = GAME_LEN;
        end else if (sel_single) begin
          state_d      = ST_GAME;
          two_player_d = 1'b0;
          time_left_d  = GAME_LEN;
        end else if (sel_tutorial) begin
          state_d = ST_TUTORIAL;
        end
      end
      ST_TUTORIAL: begin
        if (end_tutorial || end_game_early) begin
          state_d = ST_SCORE;
        end
      end
      ST_GAME: begin
        // An abort freezes the clock where it stands, even on a tick.
        if (end_game_early) begin
          state_d = ST_SCORE;
        end else if (tick) begin
          if (time_left_q <= 8'd1) begin
            time_left_d = 8'd0;
            state_d     = ST_SCORE;
          end else begin
            time_left_d = time_left_q - 8'd1;
          end
        end
      end
      ST_SCORE: begin
        if (tick && (secs_inc == SCORE_LEN)) begin
          state_d = ST_AGAIN;
        end
      end
      ST_AGAIN: begin
        if (restart) begin
          state_d      = ST_SELECT;
          time_left_d  = 8'd0;
          two_player_d = 1'b0;
        end
      end
      default: begin
        // Unused encodings recover to the logo screen with clean data.
        state_d      = ST_LOGO;
        time_left_d  = 8'd0;
        two_player_d = 1'b0;
      end
    endcase
  end

  // Prescaler and phase seconds restart on every transition so each timed
  // phase begins on a whole-second boundary.
  always_comb begin
    transition = (state_d != state_q);
    if (transition || tick) begin
      presc_d = '0;
    end else begin
      presc_d = presc_q + 1'b1;
    end
    if (transition) begin
      secs_d = 8'd0;
    end else if (tick) begin
      secs_d = secs_inc;
    end else begin
      secs_d = secs_q;
    end
  end

  // Screen flags and snitch window decoded from next-state values.
  always_comb begin
    logo_d     = (state_d == ST_LOGO);
    select_d   = (state_d == ST_SELECT);
    tutorial_d = (state_d == ST_TUTORIAL);
    game_d     = (state_d == ST_GAME);
    score_d    = (state_d == ST_SCORE);
    again_d    = (state_d == ST_AGAIN);
    snitch_d   = (state_d == ST_GAME) &&
                 (time_left_d >= SNITCH_FLOOR) &&
                 (time_left_d <= SNITCH_TOP);
  end

  // All state, counters and flags, cleared asynchronously.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q      <= ST_LOGO;
      presc_q      <= '0;
      secs_q       <= 8'd0;
      time_left_q  <= 8'd0;
      two_player_q <= 1'b0;
      logo_q       <= 1'b1;
      select_q     <= 1'b0;
      tutorial_q   <= 1'b0;
      game_q       <= 1'b0;
      score_q      <= 1'b0;
      again_q      <= 1'b0;
      snitch_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      presc_q      <= presc_d;
      secs_q       <= secs_d;
      time_left_q  <= time_left_d;
      two_player_q <= two_player_d;
      logo_q       <= logo_d;
      select_q     <= select_d;
      tutorial_q   <= tutorial_d;
      game_q       <= game_d;
      score_q      <= score_d;
      again_q      <= again_d;
      snitch_q     <= snitch_d;
    end
  end

  // Output mapping.
  always_comb begin
    phase              = state_q;
    logo               = logo_q;
    select_mode_screen = select_q;
    tutorial_active    = tutorial_q;
    game_active        = game_q;
    two_player_mode    = two_player_q;
    end_of_game        = score_q;
    play_again         = again_q;
    snitch_powerup     = snitch_q;
    time_left          = time_left_q;
    sec_tick           = tick;
  end

endmodule

// File: tb/tb_game_phase_sequencer.sv
// Bench for game_phase_sequencer: directed scenarios followed by a random
// soak, every cycle compared against a phase/elapsed-time reference model.
module tb_game_phase_sequencer;

  localparam int CLK_HZ     = 4;
  localparam int LOGO_SECS  = 2;
  localparam int GAME_SECS  = 5;
  localparam int SNITCH_HI  = 4;
  localparam int SNITCH_LO  = 3;
  localparam int SCORE_SECS = 1;

  localparam int P_LOGO = 0, P_SELECT = 1, P_TUT = 2, P_GAME = 3, P_SCORE = 4, P_AGAIN = 5;

  logic       clock = 1'b0;
  logic       resetn = 1'b0;
  logic       sel_single = 1'b0, sel_two_player = 1'b0, sel_tutorial = 1'b0;
  logic       end_game_early = 1'b0, end_tutorial = 1'b0, restart = 1'b0;
  logic [2:0] phase;
  logic       logo, select_mode_screen, tutorial_active, game_active;
  logic       two_player_mode, end_of_game, play_again, snitch_powerup, sec_tick;
  logic [7:0] time_left;

  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;

  // Reference model: phase, cycles spent in the phase, seconds left, mode.
  int m_ph, m_cyc, m_tl;
  bit m_two;

  // Clock
  always #5 clock = ~clock;

  game_phase_sequencer #(
    .CLK_HZ(CLK_HZ), .LOGO_SECS(LOGO_SECS), .GAME_SECS(GAME_SECS),
    .SNITCH_HI(SNITCH_HI), .SNITCH_LO(SNITCH_LO), .SCORE_SECS(SCORE_SECS)
  ) dut (
    .clock(clock), .resetn(resetn),
    .sel_single(sel_single), .sel_two_player(sel_two_player), .sel_tutorial(sel_tutorial),
    .end_game_early(end_game_early), .end_tutorial(end_tutorial), .restart(restart),
    .phase(phase), .logo(logo), .select_mode_screen(select_mode_screen),
    .tutorial_active(tutorial_active), .game_active(game_active),
    .two_player_mode(two_player_mode), .end_of_game(end_of_game),
    .play_again(play_again), .snitch_powerup(snitch_powerup),
    .time_left(time_left), .sec_tick(sec_tick)
  );

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic bit m_tick();
    return (m_cyc % CLK_HZ) == (CLK_HZ - 1);
  endfunction

  task automatic model_reset();
    m_ph  = P_LOGO;
    m_cyc = 0;
    m_tl  = 0;
    m_two = 1'b0;
  endtask

  task automatic model_step();
    int nph;
    nph = m_ph;
    case (m_ph)
      P_LOGO:   if (m_cyc + 1 == LOGO_SECS * CLK_HZ) nph = P_SELECT;
      P_SELECT: begin
        if (sel_two_player) begin nph = P_GAME; m_two = 1'b1; m_tl = GAME_SECS; end
        else if (sel_single) begin nph = P_GAME; m_two = 1'b0; m_tl = GAME_SECS; end
        else if (sel_tutorial) nph = P_TUT;
      end
      P_TUT:    if (end_tutorial || end_game_early) nph = P_SCORE;
      P_GAME: begin
        if (end_game_early) nph = P_SCORE;
        else if (m_tick()) begin
          m_tl = GAME_SECS - (m_cyc + 1) / CLK_HZ;
          if (m_tl == 0) nph = P_SCORE;
        end
      end
      P_SCORE:  if (m_cyc + 1 == SCORE_SECS * CLK_HZ) nph = P_AGAIN;
      P_AGAIN:  if (restart) begin nph = P_SELECT; m_tl = 0; m_two = 1'b0; end
      default:  nph = P_LOGO;
    endcase
    if (nph != m_ph) begin
      m_ph  = nph;
      m_cyc = 0;
    end else begin
      m_cyc = m_cyc + 1;
    end
  endtask

  // Scoreboard comparison point.
  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_checks = n_checks + 1;
    assert (obs === exp) n_pass = n_pass + 1;
    else begin
      n_fail = n_fail + 1;
      $error("FAIL %s: observed %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic check_all();
    chk("phase", 8'(phase), 8'(m_ph));
    chk("logo", 8'(logo), 8'(m_ph == P_LOGO));
    chk("select_mode_screen", 8'(select_mode_screen), 8'(m_ph == P_SELECT));
    chk("tutorial_active", 8'(tutorial_active), 8'(m_ph == P_TUT));
    chk("game_active", 8'(game_active), 8'(m_ph == P_GAME));
    chk("end_of_game", 8'(end_of_game), 8'(m_ph == P_SCORE));
    chk("play_again", 8'(play_again), 8'(m_ph == P_AGAIN));
    chk("two_player_mode", 8'(two_player_mode), 8'(m_two));
    chk("time_left", time_left, 8'(m_tl));
    chk("snitch_powerup", 8'(snitch_powerup),
        8'(m_ph == P_GAME && m_tl >= SNITCH_LO && m_tl <= SNITCH_HI));
    chk("sec_tick", 8'(sec_tick), 8'(m_tick()));
  endtask

  // Driver: one clock; model follows the DUT only when out of reset.
  task automatic cycle();
    @(posedge clock);
    if (resetn) model_step();
    @(negedge clock);
    check_all();
  endtask

  function automatic logic flag_of(input int which);
    case (which)
      P_LOGO:   return logo;
      P_SCORE:  return end_of_game;
      P_AGAIN:  return play_again;
      default:  return snitch_powerup;
    endcase
  endfunction

  // Count consecutive samples (starting now) where a flag is high.
  task automatic count_run(input int which, input int budget, output int c);
    c = 0;
    if (flag_of(which)) begin
      c = 1;
      for (int n = 0; n < budget; n++) begin
        cycle();
        if (flag_of(which)) c = c + 1;
        else break;
      end
    end
  endtask

  task automatic wait_phase(input int target, input int budget);
    for (int n = 0; n < budget && m_ph != target; n++) cycle();
    chk("wait_phase", 8'(phase), 8'(target));
  endtask

  task automatic do_restart();
    wait_phase(P_AGAIN, 40);
    restart = 1'b1;
    cycle();
    restart = 1'b0;
    chk("restart_phase", 8'(phase), 8'(P_SELECT));
    chk("restart_time_left", time_left, 8'd0);
    chk("restart_two_player", 8'(two_player_mode), 8'd0);
  endtask

  initial begin
    int c;
    int t;
    model_reset();
    repeat (2) @(negedge clock);
    check_all();
    chk("reset_logo", 8'(logo), 8'd1);
    resetn = 1'b1;

    // Logo lasts exactly LOGO_SECS*CLK_HZ cycles.
    count_run(P_LOGO, 50, c);
    chk("logo_cycles", 8'(c), 8'd8);
    chk("select_after_logo", 8'(select_mode_screen), 8'd1);
    t = 0;
    for (int i = 0; i < 12; i++) begin
      if (sec_tick) t = t + 1;
      cycle();
    end
    chk("select_ticks_in_12", 8'(t), 8'd3);
    chk("select_holds", 8'(select_mode_screen), 8'd1);

    // Two-player wins priority over single; full match.
    sel_single = 1'b1; sel_two_player = 1'b1;
    cycle();
    sel_single = 1'b0; sel_two_player = 1'b0;
    chk("game_entry_two", 8'(two_player_mode), 8'd1);
    chk("game_entry_time", time_left, 8'd5);
    c = 0;
    for (int n = 0; n < 40 && game_active; n++) begin
      if (snitch_powerup) c = c + 1;
      cycle();
    end
    chk("snitch_cycles", 8'(c), 8'd8);
    chk("score_after_match", 8'(phase), 8'(P_SCORE));
    chk("score_time_zero", time_left, 8'd0);
    count_run(P_SCORE, 20, c);
    chk("score_cycles", 8'(c), 8'd4);
    c = 0;
    for (int n = 0; n < 100; n++) begin
      sel_single = 1'($urandom_range(0, 1));
      sel_two_player = 1'($urandom_range(0, 1));
      sel_tutorial = 1'($urandom_range(0, 1));
      cycle();
      if (play_again) c = c + 1;
    end
    sel_single = 1'b0; sel_two_player = 1'b0; sel_tutorial = 1'b0;
    chk("again_hold_cycles", 8'(c), 8'd100);
    do_restart();

    // Single-player match aborted on a coincident tick at time_left=3.
    sel_single = 1'b1;
    cycle();
    sel_single = 1'b0;
    chk("single_two_player", 8'(two_player_mode), 8'd0);
    for (int n = 0; n < 40 && !(m_ph == P_GAME && m_tl == 3 && m_tick()); n++) cycle();
    chk("abort_pre_tick", 8'(sec_tick), 8'd1);
    end_game_early = 1'b1;
    cycle();
    end_game_early = 1'b0;
    chk("abort_phase", 8'(phase), 8'(P_SCORE));
    chk("abort_time_left", time_left, 8'd3);
    chk("abort_snitch", 8'(snitch_powerup), 8'd0);
    do_restart();

    // Tutorial path.
    sel_tutorial = 1'b1;
    cycle();
    sel_tutorial = 1'b0;
    chk("tutorial_active", 8'(tutorial_active), 8'd1);
    chk("tutorial_time_left", time_left, 8'd0);
    repeat ($urandom_range(2, 9)) cycle();
    end_tutorial = 1'b1;
    cycle();
    end_tutorial = 1'b0;
    count_run(P_SCORE, 20, c);
    chk("tutorial_score_cycles", 8'(c), 8'd4);
    do_restart();

    // Reset in the middle of a match.
    sel_two_player = 1'b1;
    cycle();
    sel_two_player = 1'b0;
    repeat (6) cycle();
    resetn = 1'b0;
    #1;
    model_reset();
    chk("midreset_phase", 8'(phase), 8'd0);
    chk("midreset_logo", 8'(logo), 8'd1);
    chk("midreset_time_left", time_left, 8'd0);
    cycle();
    resetn = 1'b1;
    count_run(P_LOGO, 50, c);
    chk("midreset_logo_cycles", 8'(c), 8'd8);

    // Random soak against the model.
    for (int i = 0; i < 1500; i++) begin
      sel_single     = ($urandom_range(0, 7) == 0);
      sel_two_player = ($urandom_range(0, 7) == 0);
      sel_tutorial   = ($urandom_range(0, 7) == 0);
      end_game_early = ($urandom_range(0, 15) == 0);
      end_tutorial   = ($urandom_range(0, 7) == 0);
      restart        = ($urandom_range(0, 5) == 0);
      if ($urandom_range(0, 299) == 0) begin
        resetn = 1'b0;
        #1;
        model_reset();
        check_all();
        cycle();
        resetn = 1'b1;
      end else begin
        cycle();
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
